// File: rtl/dvi_tx_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// dvi_tx_timing_ctrl_if
// Read-request handshake between the timing controller and an upstream
// first-word-fall-through pixel source.
//   pix_req   : read strobe from the controller; the word on pix_data is
//               consumed in the same cycle the strobe is high
//   pix_valid : source has a word on pix_data
//   pix_data  : {r[7:0], g[7:0], b[7:0]}
// master = timing controller side, slave = pixel source side.
// ---------------------------------------------------------------------------
interface dvi_tx_timing_ctrl_if;
    logic        pix_req;
    logic        pix_valid;
    logic [23:0] pix_data;

    modport master (
        output pix_req,
        input  pix_valid,
        input  pix_data
    );

    modport slave (
        input  pix_req,
        output pix_valid,
        output pix_data
    );
endinterface

// File: rtl/dvi_tx_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dvi_tx_timing_ctrl
// Video timing sequencer for the DVI/HDMI transmit path. A 12-bit h/v counter
// pair walks the programmed raster (active, front porch, sync, back porch),
// pulls pixels from an FWFT source while inside the active window, and
// presents registered, mutually aligned sync/de/rgb/x/y to the TMDS encoder.
// Output starts and stops only on frame boundaries.
// Ports:
//   clk, rstn         pixel clock, asynchronous active-low reset
//   i_en              run request (level)
//   i_underflow_clr   clears the sticky underflow flag
//   pix_if            pixel source handshake (master side)
//   o_hs, o_vs, o_de  sync and data enable to the encoder
//   o_r, o_g, o_b     pixel to the encoder
//   o_x, o_y          coordinates of the pixel currently on the outputs
//   o_frame_start     one-cycle pulse with the first active pixel of a frame
//   o_busy            sequencer is not idle
//   o_underflow       sticky: a request found the source empty
// ---------------------------------------------------------------------------
module dvi_tx_timing_ctrl #(
    parameter int          H_ACTIVE = 1280,
    parameter int          H_FP     = 110,
    parameter int          H_SYNC   = 40,
    parameter int          H_BP     = 220,
    parameter int          V_ACTIVE = 720,
    parameter int          V_FP     = 5,
    parameter int          V_SYNC   = 5,
    parameter int          V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter logic [23:0] FILL     = 24'h000000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_en,
    input  logic                        i_underflow_clr,
    dvi_tx_timing_ctrl_if.master        pix_if,
    output logic                        o_hs,
    output logic                        o_vs,
    output logic                        o_de,
    output logic [7:0]                  o_r,
    output logic [7:0]                  o_g,
    output logic [7:0]                  o_b,
    output logic [11:0]                 o_x,
    output logic [11:0]                 o_y,
    output logic                        o_frame_start,
    output logic                        o_busy,
    output logic                        o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;

    logic        w_h_end;
    logic        w_v_end;
    logic        w_frame_end;
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;
    logic        w_busy;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_hs_win;
    logic        w_vs_win;
    logic        w_pix_req;

    // Counter stage: raster position and run state
    assign w_h_end     = (r_h_cnt == H_LAST);
    assign w_v_end     = (r_v_cnt == V_LAST);
    assign w_frame_end = w_h_end & w_v_end;
    assign w_h_nxt     = w_h_end ? 12'd0 : r_h_cnt + 12'd1;
    assign w_v_nxt     = w_h_end ? (w_v_end ? 12'd0 : r_v_cnt + 12'd1) : r_v_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_h_cnt <= 12'd0;
            r_v_cnt <= 12'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_h_cnt <= 12'd0;
                    r_v_cnt <= 12'd0;
                    if (i_en) r_state <= S_RUN;
                end
                S_RUN, S_DRAIN: begin
                    // A stop request seen on the last pixel of a frame ends it
                    // right there; otherwise keep walking the raster and let
                    // i_en choose between running and draining, so re-raising
                    // i_en while draining never breaks the timing.
                    if (!i_en && w_frame_end) begin
                        r_state <= S_IDLE;
                        r_h_cnt <= 12'd0;
                        r_v_cnt <= 12'd0;
                    end else begin
                        r_state <= i_en ? S_RUN : S_DRAIN;
                        r_h_cnt <= w_h_nxt;
                        r_v_cnt <= w_v_nxt;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_h_cnt <= 12'd0;
                    r_v_cnt <= 12'd0;
                end
            endcase
        end
    end

    // Window decodes come from flops only, so pix_req has no input path.
    assign w_busy    = (r_state != S_IDLE);
    assign w_h_act   = (r_h_cnt < H_ACT_END);
    assign w_v_act   = (r_v_cnt < V_ACT_END);
    assign w_hs_win  = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
    assign w_vs_win  = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
    assign w_pix_req = w_busy & w_h_act & w_v_act;

    assign pix_if.pix_req = w_pix_req;
    assign o_busy         = w_busy;

    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic [23:0] r_rgb;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_fs;
    logic        r_uf;

    // Output stage: everything registered from the counter stage together
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_de  <= 1'b0;
            r_rgb <= 24'd0;
            r_x   <= 12'd0;
            r_y   <= 12'd0;
            r_fs  <= 1'b0;
            r_uf  <= 1'b0;
        end else begin
            // Counters sit at (0,0) in idle, so only the sync levels need forcing.
            r_hs <= w_busy ? (w_hs_win ~^ HS_POL) : ~HS_POL;
            r_vs <= w_busy ? (w_vs_win ~^ VS_POL) : ~VS_POL;
            r_de <= w_pix_req;
            r_x  <= r_h_cnt;
            r_y  <= r_v_cnt;
            r_fs <= w_pix_req && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
            if (w_pix_req)
                r_rgb <= pix_if.pix_valid ? pix_if.pix_data : FILL;
            else
                r_rgb <= 24'd0;
            // A new underflow takes priority over a simultaneous clear.
            if (w_pix_req && !pix_if.pix_valid)
                r_uf <= 1'b1;
            else if (i_underflow_clr)
                r_uf <= 1'b0;
        end
    end

    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_de          = r_de;
    assign o_r           = r_rgb[23:16];
    assign o_g           = r_rgb[15:8];
    assign o_b           = r_rgb[7:0];
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_fs;
    assign o_underflow   = r_uf;

endmodule

// File: tb/tb_dvi_tx_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dvi_tx_timing_ctrl
// Two instances share all stimulus: dut0 with active-high syncs, dut1 with
// active-low syncs. Raster 8 x 6 clocks (H 4/1/2/1, V 3/1/1/1). The reference
// model describes a frame as a position p = 0..47 with x = p % 8, y = p / 8,
// and predicts each output-stage value one clock ahead into a queue.
// ---------------------------------------------------------------------------
module tb_dvi_tx_timing_ctrl;

    localparam logic [23:0] FILL_V = 24'hA5C3E1;
    localparam int HT = 8;
    localparam int VT = 6;
    localparam int FT = HT * VT;

    typedef struct {
        bit          de, hs, vs, fs, busy, uf, req;
        logic [23:0] rgb;
        int          x, y;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, en, clr;

    dvi_tx_timing_ctrl_if pif0 ();
    dvi_tx_timing_ctrl_if pif1 ();

    logic        hs0, vs0, de0, fs0, busy0, uf0;
    logic [7:0]  r0, g0, b0;
    logic [11:0] x0, y0;
    logic        hs1, vs1, de1, fs1, busy1, uf1;
    logic [7:0]  r1, g1, b1;
    logic [11:0] x1, y1;

    dvi_tx_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FILL(FILL_V)
    ) dut0 (
        .clk(clk), .rstn(rstn), .i_en(en), .i_underflow_clr(clr),
        .pix_if(pif0.master),
        .o_hs(hs0), .o_vs(vs0), .o_de(de0),
        .o_r(r0), .o_g(g0), .o_b(b0), .o_x(x0), .o_y(y0),
        .o_frame_start(fs0), .o_busy(busy0), .o_underflow(uf0)
    );

    dvi_tx_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FILL(FILL_V)
    ) dut1 (
        .clk(clk), .rstn(rstn), .i_en(en), .i_underflow_clr(clr),
        .pix_if(pif1.master),
        .o_hs(hs1), .o_vs(vs1), .o_de(de1),
        .o_r(r1), .o_g(g1), .o_b(b1), .o_x(x1), .o_y(y1),
        .o_frame_start(fs1), .o_busy(busy1), .o_underflow(uf1)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    int   fs_q[$];
    int   cyc = 0;
    int   busy_fall_cyc = -1;

    // reference model state
    bit          m_on = 1'b0;
    int          m_p  = 0;
    bit          m_uf = 1'b0;
    logic [23:0] src  = 24'h000001;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compute what the outputs must show after the coming clock edge, then
    // advance the model by one clock.
    task automatic apply(input bit e, input bit v, input bit c);
        exp_t ex;
        int   hx, vy;
        bit   req;
        en  = e;
        clr = c;
        pif0.pix_valid = v;
        pif1.pix_valid = v;
        pif0.pix_data  = v ? src : ~src;
        pif1.pix_data  = v ? src : ~src;
        hx  = m_p % HT;
        vy  = m_p / HT;
        req = m_on && (hx < 4) && (vy < 3);
        ex.de  = req;
        ex.hs  = m_on && (hx == 5 || hx == 6);
        ex.vs  = m_on && (vy == 4);
        ex.x   = hx;
        ex.y   = vy;
        ex.fs  = req && (m_p == 0);
        ex.rgb = req ? (v ? src : FILL_V) : 24'd0;
        if (req && !v)  m_uf = 1'b1;
        else if (c)     m_uf = 1'b0;
        ex.uf = m_uf;
        if (req && v) src = src + 24'h010203;
        if (!m_on) begin
            if (e) begin m_on = 1'b1; m_p = 0; end
        end else if (!e && m_p == FT - 1) begin
            m_on = 1'b0; m_p = 0;
        end else begin
            m_p = (m_p + 1) % FT;
        end
        ex.busy = m_on;
        ex.req  = m_on && ((m_p % HT) < 4) && ((m_p / HT) < 3);
        q.push_back(ex);
    endtask

    task automatic step(input bit e, input bit v, input bit c);
        @(negedge clk);
        apply(e, v, c);
    endtask

    task automatic run_to(input int target, input bit e);
        int guard = 0;
        while ((!m_on || m_p != target) && guard < 200) begin
            step(e, 1'b1, 1'b0);
            guard++;
        end
        chk("reach_position", (guard < 200) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_de", de0, 0);
        chk("rst_hs", hs0, 0);
        chk("rst_vs", vs0, 0);
        chk("rst_hs_lowpol", hs1, 1);
        chk("rst_vs_lowpol", vs1, 1);
        chk("rst_rgb", {r0, g0, b0}, 0);
        chk("rst_xy", {x0, y0}, 0);
        chk("rst_fs", fs0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_uf", uf0, 0);
        chk("rst_req", pif0.pix_req, 0);
    endtask

    // Monitor: one expected entry per clock while stimulus is active.
    initial begin
        exp_t e;
        bit   prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (fs0) fs_q.push_back(cyc);
            if (prev_busy && !busy0) busy_fall_cyc = cyc;
            prev_busy = busy0;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("de", de0, e.de);
                chk("hs", hs0, e.hs);
                chk("vs", vs0, e.vs);
                chk("rgb", {r0, g0, b0}, e.rgb);
                chk("x", x0, e.x);
                chk("y", y0, e.y);
                chk("frame_start", fs0, e.fs);
                chk("busy", busy0, e.busy);
                chk("underflow", uf0, e.uf);
                chk("pix_req", pif0.pix_req, e.req);
                chk("hs_lowpol", hs1, !e.hs);
                chk("vs_lowpol", vs1, !e.vs);
                chk("de_lowpol", de1, e.de);
                chk("rgb_lowpol", {r1, g1, b1}, e.rgb);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rel_cyc;
        int  last_fs;
        bit  en_r;
        rstn = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        pif0.pix_valid = 1'b1; pif1.pix_valid = 1'b1;
        pif0.pix_data  = 24'd0; pif1.pix_data = 24'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rstn = 1'b1;

        // idle with en low
        repeat (100) step(1'b0, 1'b1, 1'b0);

        // three uninterrupted frames
        fs_q.delete();
        repeat (3 * FT + 2) step(1'b1, 1'b1, 1'b0);
        chk("fs_count", (fs_q.size() >= 3) ? 1 : 0, 1);
        if (fs_q.size() >= 3) begin
            chk("fs_period_a", fs_q[1] - fs_q[0], FT);
            chk("fs_period_b", fs_q[2] - fs_q[1], FT);
        end

        // underflow at (2,1), then set-beats-clear, then a clean clear
        run_to(10, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0);
        run_to(10, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);

        // drop en at (1,1): the frame completes and busy falls.
        // frame_start lags the (0,0) counter cycle by one clock, so busy falling
        // 48 clocks after frame start is 47 monitor cycles after the pulse.
        run_to(9, 1'b1);
        last_fs = (fs_q.size() > 0) ? fs_q[$] : -1000;
        busy_fall_cyc = -1;
        begin
            int guard = 0;
            while (m_on && guard < 100) begin
                step(1'b0, 1'b1, 1'b0);
                guard++;
            end
        end
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("drain_len", busy_fall_cyc - last_fs, FT - 1);

        // restart, drop en mid-frame, re-raise during drain: no gap
        fs_q.delete();
        step(1'b1, 1'b1, 1'b0);
        run_to(20, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (FT + 10) step(1'b1, 1'b1, 1'b0);
        chk("redrain_fs_count", (fs_q.size() >= 2) ? 1 : 0, 1);
        if (fs_q.size() >= 2) chk("redrain_fs_period", fs_q[1] - fs_q[0], FT);

        // randomized run
        en_r = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            step(en_r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
        end

        // asynchronous reset mid-line
        run_to(2, 1'b1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_vals();
        m_on = 1'b0; m_p = 0; m_uf = 1'b0;
        repeat (3) @(negedge clk);
        fs_q.delete();
        @(negedge clk);
        rel_cyc = cyc;
        rstn = 1'b1;
        apply(1'b1, 1'b1, 1'b0);
        repeat (60) step(1'b1, 1'b1, 1'b0);
        chk("post_rst_fs_seen", (fs_q.size() > 0) ? 1 : 0, 1);
        if (fs_q.size() > 0) chk("post_rst_fs_delay", fs_q[0] - rel_cyc, 2);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
